// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, press/release qualification FSM,
// single-cycle press/release/long-press pulses and a run/pause toggle.
module button_debounce #(
    parameter int CNT_MAX  = 10000,
    parameter int LONG_MAX = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic toggle
);

    localparam int CW = $clog2(CNT_MAX);
    localparam int HW = $clog2(LONG_MAX);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_done_q, long_done_d;
    logic          key_level_q, key_level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          toggle_q, toggle_d;
    logic          holding;
    logic          release_accept;

    always_comb begin
        s1_d           = key_in;
        s2_d           = s1_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        hcnt_d         = hcnt_q;
        long_done_d    = long_done_q;
        key_level_d    = key_level_q;
        press_d        = 1'b0;
        release_d      = 1'b0;
        long_d         = 1'b0;
        toggle_d       = toggle_q;
        release_accept = 1'b0;
        holding        = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

        // The hold timer keeps running through release bounces so they never restart it.
        if (holding && (hcnt_q != HCNT_LAST)) begin
            hcnt_d = hcnt_q + HW'(1);
        end

        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = PRESSED;
                    hcnt_d      = '0;
                    long_done_d = 1'b0;
                    key_level_d = 1'b1;
                    press_d     = 1'b1;
                    toggle_d    = ~toggle_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = IDLE;
                    key_level_d    = 1'b0;
                    release_d      = 1'b1;
                    release_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accepted release in the same cycle suppresses the long-press pulse.
        if (holding && (hcnt_q == HCNT_LAST) && !long_done_q && !release_accept) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            long_done_q <= 1'b0;
            key_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            toggle_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            key_level_q <= key_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            toggle_q    <= toggle_d;
        end
    end

    assign key_level     = key_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign toggle        = toggle_q;

    a_no_press_and_release: assert property (@(posedge clk) disable iff (!rst)
        !(press_pulse && release_pulse));
    a_press_one_cycle: assert property (@(posedge clk) disable iff (!rst)
        press_pulse |=> !press_pulse);
    a_release_one_cycle: assert property (@(posedge clk) disable iff (!rst)
        release_pulse |=> !release_pulse);
    a_long_one_cycle: assert property (@(posedge clk) disable iff (!rst)
        long_pulse |=> !long_pulse);

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed test-plan scenarios plus random
// key/reset traffic, all compared each cycle against a run-length behavioural model.
module tb_button_debounce;

    localparam int CNT_MAX  = 4;
    localparam int LONG_MAX = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_in = 1'b0;
    logic key_level, press_pulse, release_pulse, long_pulse, toggle;

    button_debounce #(
        .CNT_MAX (CNT_MAX),
        .LONG_MAX(LONG_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .toggle       (toggle)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model state: synchronizer image, accepted level, and a run length of edges
    // on which the synchronized key disagreed with the accepted level.
    bit m_s1, m_s2, m_level, m_toggle, m_press, m_rel, m_long, long_armed;
    int run = 0;
    int press_edge = 0;

    int press_cnt = 0, rel_cnt = 0, long_cnt = 0;
    int last_press_edge = 0, last_long_edge = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at edge %0d",
                     name, actual, expected, edge_n);
        end
    endtask

    function automatic void model_step();
        bit accept;
        edge_n++;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (!rst) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_level = 1'b0;
            m_toggle = 1'b0;
            run = 0;
            long_armed = 1'b0;
        end else begin
            if (m_s2 != m_level) run++;
            else run = 0;
            accept = (run == CNT_MAX + 1);
            if (accept) begin
                run = 0;
                if (!m_level) begin
                    m_level = 1'b1;
                    m_press = 1'b1;
                    m_toggle = ~m_toggle;
                    press_edge = edge_n;
                    long_armed = 1'b1;
                end else begin
                    m_level = 1'b0;
                    m_rel = 1'b1;
                    long_armed = 1'b0;
                end
            end else if (m_level && long_armed && (edge_n - press_edge) == LONG_MAX) begin
                m_long = 1'b1;
                long_armed = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    endfunction

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_output("key_level", key_level, m_level);
        check_output("press_pulse", press_pulse, m_press);
        check_output("release_pulse", release_pulse, m_rel);
        check_output("long_pulse", long_pulse, m_long);
        check_output("toggle", toggle, m_toggle);
        if (press_pulse === 1'b1) begin
            press_cnt++;
            last_press_edge = edge_n;
        end
        if (release_pulse === 1'b1) rel_cnt++;
        if (long_pulse === 1'b1) begin
            long_cnt++;
            last_long_edge = edge_n;
        end
    endtask

    task automatic apply_stimulus(input bit k, input bit r, input int n);
        repeat (n) begin
            key_in = k;
            rst = r;
            tick();
        end
    endtask

    // Counts edges until the selected pulse appears (0 = press, 1 = release), bounded.
    task automatic wait_pulse(input int sel, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (hit !== 1'b1 && n < 30) begin
            tick();
            n++;
            hit = (sel == 0) ? press_pulse : release_pulse;
        end
    endtask

    int n, p0, r0, l0;
    int exp_tog[3] = '{1, 0, 1};

    initial begin
        // Reset held with key pressed: everything stays low.
        apply_stimulus(1'b1, 1'b0, 5);
        check_output("reset_key_level", key_level, 0);
        check_output("reset_toggle", toggle, 0);
        check_output("reset_press_count", press_cnt, 0);
        key_in = 1'b1;
        rst = 1'b1;
        wait_pulse(0, n);
        check_output("post_reset_press_latency", n, 7);
        apply_stimulus(1'b0, 1'b1, 12);

        // Clean press.
        apply_stimulus(1'b0, 1'b0, 2);
        l0 = long_cnt;
        key_in = 1'b1;
        rst = 1'b1;
        wait_pulse(0, n);
        check_output("clean_press_latency", n, 7);
        check_output("clean_press_toggle", toggle, 1);
        apply_stimulus(1'b1, 1'b1, 5);
        check_output("clean_held_level", key_level, 1);
        key_in = 1'b0;
        wait_pulse(1, n);
        check_output("clean_release_latency", n, 7);
        check_output("clean_release_level", key_level, 0);
        check_output("clean_no_long", long_cnt - l0, 0);

        // Bounce rejection.
        p0 = press_cnt;
        apply_stimulus(1'b1, 1'b1, 1);
        apply_stimulus(1'b0, 1'b1, 1);
        apply_stimulus(1'b1, 1'b1, 2);
        apply_stimulus(1'b0, 1'b1, 1);
        apply_stimulus(1'b1, 1'b1, 1);
        apply_stimulus(1'b0, 1'b1, 10);
        check_output("bounce_no_press", press_cnt - p0, 0);
        check_output("bounce_level", key_level, 0);
        check_output("bounce_toggle", toggle, 1);

        // Release bounce during a long hold.
        apply_stimulus(1'b0, 1'b0, 2);
        p0 = press_cnt;
        r0 = rel_cnt;
        l0 = long_cnt;
        key_in = 1'b1;
        rst = 1'b1;
        wait_pulse(0, n);
        apply_stimulus(1'b1, 1'b1, 5);
        apply_stimulus(1'b0, 1'b1, 2);
        apply_stimulus(1'b1, 1'b1, 30);
        check_output("rb_press_count", press_cnt - p0, 1);
        check_output("rb_no_release", rel_cnt - r0, 0);
        check_output("rb_long_count", long_cnt - l0, 1);
        check_output("rb_long_delay", last_long_edge - last_press_edge, 20);
        apply_stimulus(1'b0, 1'b1, 12);
        check_output("rb_final_release", rel_cnt - r0, 1);

        // Toggle sequence over three clean presses.
        apply_stimulus(1'b0, 1'b0, 2);
        p0 = press_cnt;
        r0 = rel_cnt;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1, 10);
            check_output("toggle_seq", toggle, exp_tog[i]);
            apply_stimulus(1'b0, 1'b1, 10);
        end
        check_output("toggle_press_count", press_cnt - p0, 3);
        check_output("toggle_release_count", rel_cnt - r0, 3);

        // Reset in the middle of a press.
        apply_stimulus(1'b0, 1'b0, 2);
        key_in = 1'b1;
        rst = 1'b1;
        wait_pulse(0, n);
        apply_stimulus(1'b1, 1'b1, 2);
        r0 = rel_cnt;
        apply_stimulus(1'b1, 1'b0, 1);
        check_output("midreset_level", key_level, 0);
        check_output("midreset_toggle", toggle, 0);
        check_output("midreset_no_release", rel_cnt - r0, 0);
        key_in = 1'b1;
        rst = 1'b1;
        wait_pulse(0, n);
        check_output("midreset_repress_latency", n, 7);
        apply_stimulus(1'b0, 1'b1, 12);

        // Random key segments with occasional resets, checked by the model every cycle.
        for (int s = 0; s < 250; s++) begin
            int len;
            bit k;
            k = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
            if ($urandom_range(0, 39) == 0) apply_stimulus(k, 1'b0, $urandom_range(1, 3));
            apply_stimulus(k, 1'b1, len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounces and edge-detects the raw run/pause push-button before it reaches the flowing-lights controller. It turns a bouncing, asynchronous key into a clean level, single-cycle press/release/long-press pulses, and a run/pause toggle that the LED controller consumes. It sits between the board push-button pin and the `button` input of the lights logic, in the same 50 MHz clock domain (20 ns period).

## Interface
- `CNT_MAX`, default 10000: number of consecutive stable samples needed to accept a press or a release; legal range ≥2.
- `LONG_MAX`, default 50000000: number of cycles in the debounced-pressed state before `long_pulse` fires; must be > `CNT_MAX`.
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  synchronous, active-low reset: sampled on rising `clk`; 0 = reset.
- `key_in`  in  1  raw button, active-high, asynchronous, may bounce.
- `key_level`  out  1  debounced key level.
- `press_pulse`  out  1  one-cycle pulse on an accepted press.
- `release_pulse`  out  1  one-cycle pulse on an accepted release.
- `long_pulse`  out  1  one-cycle pulse when a press has been held for `LONG_MAX` cycles.
- `toggle`  out  1  run/pause state. Flips on every `press_pulse`.

## Operation
- Synchronizer: two flops `key_in` → `s1` → `s2`, both reset to 0. All decisions use `s2` only.
- Debounce counter `cnt` is wide enough for `CNT_MAX-1`. Hold counter `hcnt` is wide enough for `LONG_MAX-1`; it saturates and never wraps.
- FSM states and transitions:
  - IDLE (`key_level`=0).
    - `s2`=1 → PRESS_WAIT, `cnt`←0.
  - PRESS_WAIT.
    - `s2`=0 → IDLE (bounce rejected, no pulse).
    - Otherwise `cnt`++.
    - When `cnt`==`CNT_MAX-1` and `s2`=1 → PRESSED, `hcnt`←0.
  - PRESSED (`key_level`=1).
    - `hcnt`++ until it saturates.
    - When `hcnt`==`LONG_MAX-1`, `long_pulse` is issued once per press.
    - `s2`=0 → RELEASE_WAIT, `cnt`←0.
  - RELEASE_WAIT (`key_level`=1).
    - `s2`=1 → PRESSED. `hcnt` is not cleared, so a bounce does not restart the long-press timer or re-fire `long_pulse`.
    - Otherwise `cnt`++.
    - When `cnt`==`CNT_MAX-1` and `s2`=0 → IDLE.
- Output updates are registered and take effect on the cycle the FSM enters the new state:
  - Entering PRESSED from PRESS_WAIT: `press_pulse`=1 for 1 cycle, `key_level`←1, `toggle`←~`toggle`.
  - Entering IDLE from RELEASE_WAIT: `release_pulse`=1 for 1 cycle, `key_level`←0.
  - RELEASE_WAIT→PRESSED produces no `press_pulse`.
- Each pulse is high for exactly one cycle. `press_pulse` and `release_pulse` are never high in the same cycle.
- If the release is accepted in the same cycle that `hcnt` reaches `LONG_MAX-1`, the release wins and `long_pulse` is not issued.

## Timing
- Reset (`rst`=0 at a rising edge): on the next edge the state is IDLE, `cnt`=`hcnt`=0, `s1`=`s2`=0, and all outputs are 0, including `toggle`.
  - Reset mid-press drops `key_level` and `toggle` to 0 with no `release_pulse`.
  - After reset deasserts, a held key is handled as a new press.
- Press latency: `key_in` is stable high from the first edge that samples it.
  - `s2`=1 two edges later.
  - PRESS_WAIT one edge after that.
  - `press_pulse` high exactly `CNT_MAX`+3 edges after the first sample.
- Release latency: `release_pulse` follows the first sample of `key_in`=0 by `CNT_MAX`+3 edges, by the same counting.
- Long press: `long_pulse` is high `LONG_MAX` cycles after `press_pulse`, provided the press is held.
- Glitch rejection: any high glitch on `s2` shorter than `CNT_MAX` cycles produces no output change. The same holds for low glitches while pressed.
- There is no combinational path from `key_in` to any output.

## Test plan
Run with `CNT_MAX`=4, `LONG_MAX`=20, 20 ns clock.
- Reset: hold `rst`=0 for 5 cycles with `key_in`=1 → all outputs 0 throughout. After `rst`=1, `press_pulse` fires 7 edges after the first sample (`CNT_MAX`+3).
- Clean press: `key_in`=1 for 12 cycles, then 0 → `press_pulse` and `toggle`=1 at edge 7. `release_pulse` at edge 7 after the falling sample. `key_level` is high between the two pulses. No `long_pulse`.
- Bounce rejection: `key_in` pattern 1,0,1,1,0,1,0 with 1-cycle steps, then 0 → no pulses, `key_level` stays 0, `toggle` unchanged.
- Release bounce: press held, then `key_in` drops for 2 cycles and returns high for 30 cycles → no `release_pulse`, no second `press_pulse`. Exactly one `long_pulse`, 20 cycles after `press_pulse`.
- Toggle sequence: three clean presses → `toggle` goes 1, 0, 1. Exactly three `press_pulse` and three `release_pulse`.
- Mid-press reset: assert `rst`=0 while in PRESSED → `key_level`=0 and `toggle`=0 on the next edge, no `release_pulse`. With the key still held after release of reset, a fresh `press_pulse` fires after 7 edges.
